addsub_seq_unit: RTL and testbench

Parametrised, multi-cycle add/subtract unit that generalises the team's 8-bit flag-producing subtractor to WIDTH bits. It computes in CHUNK-bit slices over WIDTH/CHUNK cycles behind a valid/ready handshake, adds a stored carry/borrow for multi-precision chaining, and returns a 4-bit flag vector. It sits in the EX stage as the arithmetic back end of the pipeline.

---
 rtl/addsub_seq_unit.sv | 145 ++++++++++++++
 tb/tb_addsub_seq_unit.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/addsub_seq_unit.sv
// addsub_seq_unit
// Multi-cycle add/subtract unit. Operands are processed CHUNK bits per cycle
// over WIDTH/CHUNK cycles behind a valid/ready handshake. A stored carry is
// kept between operations so SBB can chain multi-precision subtraction.
// Flags: [0] carry, [1] zero, [2] signed overflow, [3] parity.
// Optional build macro: ADDSUB_SAT_EN makes ADD/SUB saturate on signed overflow.
module addsub_seq_unit #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             busy
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_CMP = 2'b10;
  localparam logic [1:0] OP_SBB = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] aOp_q, bOp_q, wrk_q, result_q;
  logic [1:0]       op_q;
  logic             carry_q, storedCarry_q;
  logic [3:0]       flags_q;

  logic             lastSlice;
  int               sliceBase;
  logic [CHUNK-1:0] aSlice, bSlice, sliceSum;
  logic             ripple, carryIntoMsb, carryOut, overflow;
  logic [WIDTH-1:0] wrk_d, result_d;
  logic [3:0]       flags_d;

  assign lastSlice = (cnt_q == CW'(N - 1));

  // State register: the FSM only advances on clock edges, reset returns to IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: accept in IDLE, walk the slices in RUN, wait for the consumer in DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (lastSlice) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: handshake and busy signals depend on the state alone.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  assign result = result_q;
  assign flags  = flags_q;

  // Slice adder: ripple CHUNK bits, then build the full result and flags for the final slice.
  always_comb begin
    sliceBase    = int'(cnt_q) * CHUNK;
    aSlice       = aOp_q[sliceBase +: CHUNK];
    bSlice       = bOp_q[sliceBase +: CHUNK];
    sliceSum     = '0;
    ripple       = carry_q;
    carryIntoMsb = carry_q;
    for (int i = 0; i < CHUNK; i++) begin
      sliceSum[i] = aSlice[i] ^ bSlice[i] ^ ripple;
      if (i == CHUNK - 1) carryIntoMsb = ripple;
      ripple = (aSlice[i] & bSlice[i]) | (ripple & (aSlice[i] ^ bSlice[i]));
    end
    carryOut = ripple;
    wrk_d = wrk_q;
    wrk_d[sliceBase +: CHUNK] = sliceSum;
    overflow = carryIntoMsb ^ carryOut;
    result_d = wrk_d;
`ifdef ADDSUB_SAT_EN
    if (((op_q == OP_ADD) || (op_q == OP_SUB)) && overflow)
      result_d = wrk_d[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
`endif
    flags_d = {^result_d, overflow, (result_d == '0), carryOut};
  end

  // Datapath registers: latch operands on accept, accumulate slices, commit on the last slice.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q         <= '0;
      aOp_q         <= '0;
      bOp_q         <= '0;
      wrk_q         <= '0;
      result_q      <= '0;
      op_q          <= OP_ADD;
      carry_q       <= 1'b0;
      storedCarry_q <= 1'b1;
      flags_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            aOp_q <= a;
            bOp_q <= (op == OP_ADD) ? b : ~b;
            op_q  <= op;
            cnt_q <= '0;
            case (op)
              OP_ADD:  carry_q <= 1'b0;
              OP_SBB:  carry_q <= storedCarry_q;
              default: carry_q <= 1'b1;
            endcase
          end
        end
        RUN: begin
          wrk_q   <= wrk_d;
          carry_q <= carryOut;
          cnt_q   <= cnt_q + 1'b1;
          if (lastSlice) begin
            flags_q       <= flags_d;
            storedCarry_q <= carryOut;
            if (op_q != OP_CMP) result_q <= result_d;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_addsub_seq_unit.sv
// Testbench for addsub_seq_unit: directed cases plus randomized operations,
// checked against an arithmetic reference model of the unit.
module tb_addsub_seq_unit;

  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int N     = WIDTH / CHUNK;
`ifdef ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [3:0]       flags;
  logic             busy;

  int testsRun;
  int testsFailed;

  // Reference model state: carry kept between ops and the visible result.
  bit               mStored;
  logic [WIDTH-1:0] mResult;

  addsub_seq_unit #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Reference model: plain integer arithmetic on the operation definition.
  task automatic refModel(input logic [1:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                          output logic [WIDTH-1:0] r, output logic [3:0] f);
    longint modv, half, ux, uy, cin, sum, sx, sy, st;
    logic [WIDTH-1:0] raw, fin;
    bit carry, ovf;
    modv  = longint'(1) << WIDTH;
    half  = modv / 2;
    ux    = longint'(x);
    uy    = (o == 2'b00) ? longint'(y) : (modv - 1 - longint'(y));
    cin   = (o == 2'b00) ? 0 : ((o == 2'b11) ? longint'(mStored) : 1);
    sum   = ux + uy + cin;
    raw   = WIDTH'(sum);
    carry = (sum >= modv);
    sx    = (ux >= half) ? ux - modv : ux;
    sy    = (uy >= half) ? uy - modv : uy;
    st    = sx + sy + cin;
    ovf   = (st >= half) || (st < -half);
    fin   = raw;
    if (SAT && (o == 2'b00 || o == 2'b01) && ovf)
      fin = (st > 0) ? WIDTH'(half - 1) : WIDTH'(half);
    f = {^fin, ovf, (fin == '0), carry};
    r = (o == 2'b10) ? mResult : fin;
    mStored = carry;
    if (o != 2'b10) mResult = fin;
  endtask

  // One full operation: request, latency, result/flags, optional backpressure, handshake.
  task automatic applyStimulus(input logic [1:0] opIn, input logic [WIDTH-1:0] aIn,
                               input logic [WIDTH-1:0] bIn, input int holdCycles, input bit earlyReady);
    logic [WIDTH-1:0] expRes;
    logic [3:0]       expFl;
    int               cycles;
    refModel(opIn, aIn, bIn, expRes, expFl);
    @(negedge clk);
    op = opIn; a = aIn; b = bIn; in_valid = 1'b1; out_ready = earlyReady;
    checkOutput("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("busy_run", 32'(busy), 32'd1);
    cycles = 0;
    while (!out_valid && cycles < 4 * N + 8) begin
      @(negedge clk);
      cycles++;
    end
    checkOutput("latency", 32'(cycles), 32'(N));
    checkOutput("result", 32'(result), 32'(expRes));
    checkOutput("flags", 32'(flags), 32'(expFl));
    if (!earlyReady) begin
      for (int k = 0; k < holdCycles; k++) begin
        in_valid = 1'b1;
        op = 2'($urandom);
        a  = WIDTH'($urandom);
        b  = WIDTH'($urandom);
        @(negedge clk);
        checkOutput("hold_valid", 32'(out_valid), 32'd1);
        checkOutput("hold_in_ready", 32'(in_ready), 32'd0);
        checkOutput("hold_result", 32'(result), 32'(expRes));
        checkOutput("hold_flags", 32'(flags), 32'(expFl));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    checkOutput("post_valid", 32'(out_valid), 32'd0);
    checkOutput("post_in_ready", 32'(in_ready), 32'd1);
    checkOutput("post_busy", 32'(busy), 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    mStored     = 1'b1;
    mResult     = '0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = 2'b00; a = '0; b = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_result", 32'(result), 32'd0);
    checkOutput("rst_flags", 32'(flags), 32'd0);
    rst_n = 1'b1;

    // Directed cases from the operation definitions.
    applyStimulus(2'b01, 16'h0005, 16'h0005, 0, 1'b0);
    checkOutput("sub_eq_flags", 32'(flags), 32'h3);
    applyStimulus(2'b01, 16'h0000, 16'h0001, 0, 1'b0);
    checkOutput("sub_borrow_res", 32'(result), 32'hFFFF);
    applyStimulus(2'b11, 16'h0000, 16'h0000, 0, 1'b0);
    checkOutput("sbb_chain_res", 32'(result), 32'hFFFF);
    checkOutput("sbb_chain_carry", 32'(flags[0]), 32'd0);
    applyStimulus(2'b00, 16'h7FFF, 16'h0001, 0, 1'b1);
    checkOutput("add_ovf_res", 32'(result), SAT ? 32'h7FFF : 32'h8000);
    checkOutput("add_ovf_flags", 32'(flags), 32'hC);
    applyStimulus(2'b00, 16'h8000, 16'h8000, 0, 1'b0);
    applyStimulus(2'b00, 16'h1000, 16'h0234, 0, 1'b0);
    applyStimulus(2'b10, 16'h0003, 16'h0009, 5, 1'b0);
    checkOutput("cmp_keeps_res", 32'(result), 32'h1234);
    applyStimulus(2'b01, 16'h8000, 16'h0001, 2, 1'b0);

    // Reset in the middle of RUN discards the op and restores the stored carry.
    @(negedge clk);
    op = 2'b01; a = 16'h00F0; b = 16'h000F; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_result", 32'(result), 32'd0);
    checkOutput("midrst_flags", 32'(flags), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    rst_n   = 1'b1;
    mStored = 1'b1;
    mResult = '0;
    applyStimulus(2'b11, 16'h0000, 16'h0000, 0, 1'b0);
    checkOutput("sbb_after_rst", 32'(result), 32'h0);

    // Randomized operations against the reference model.
    for (int t = 0; t < 60; t++) begin
      applyStimulus(2'($urandom), WIDTH'($urandom), WIDTH'($urandom),
                    int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
